common_fifo_buffer: RTL and testbench
=====================================

Name: common_fifo_buffer

Overview:
- Synchronous FIFO with first-word-fall-through behaviour and valid/ready handshakes on both sides.
- Sits directly downstream of common_cross_buffer2_priority. Its prev_* side takes that block's next_o_data/next_o_valid and drives next_i_ready.
- Absorbs consumer back-pressure so the priority merger keeps accepting while the consumer stalls.
- Exposes occupancy flags for debug and difftest.

Parameters:
- BUFFER_WIDTH, 32: data width in bits.
- BUFFER_DEPTH_LOG2, 2: log2 of the entry count. Depth = 2^BUFFER_DEPTH_LOG2 (default 4). Legal range 1..8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- prev_i_data  input  BUFFER_WIDTH  write data from upstream.
- prev_i_valid  input  1  upstream offers prev_i_data.
- prev_o_ready  output  1  FIFO can accept a word this cycle.
- next_o_data  output  BUFFER_WIDTH  head-of-queue data.
- next_o_valid  output  1  head entry is valid.
- next_i_ready  input  1  downstream accepts the head this cycle.
- o_count  output  BUFFER_DEPTH_LOG2+1  current number of stored entries.
- o_full  output  1  o_count == depth.
- o_empty  output  1  o_count == 0.

Behaviour:
- Push occurs when prev_i_valid && prev_o_ready at a rising edge. Pop occurs when next_o_valid && next_i_ready at a rising edge.
- Storage: 2^BUFFER_DEPTH_LOG2 registers of BUFFER_WIDTH.
- Pointers: write pointer and read pointer, each BUFFER_DEPTH_LOG2+1 bits. The MSB is the wrap bit, and both pointers increment modulo 2^(BUFFER_DEPTH_LOG2+1).
- Full: low bits equal, wrap bits differ. Empty: pointers equal in all bits.
- o_count = wr_ptr - rd_ptr, computed modulo 2^(BUFFER_DEPTH_LOG2+1).
- prev_o_ready = !o_full && !reset.
  - Ready does not depend on next_i_ready. When full, a simultaneous pop does NOT enable a push in the same cycle (no ready pass-through).
- next_o_valid = !o_empty && !reset. next_o_data = storage[rd_ptr low bits], combinational from registers. No write-to-read bypass.
- Latency: a word pushed at edge N is presented with next_o_valid=1 in the cycle after edge N and can be popped at edge N+1 at the earliest. Minimum latency is 1 cycle.
- Simultaneous push and pop when non-empty and not full: both pointers advance and o_count is unchanged.
- Simultaneous push and pop with o_count==1: the head advances to the newly written word, and next_o_valid stays 1.
- Push with prev_o_ready=0 is ignored; no state change.
- Pop with next_o_valid=0 is ignored.
- Data stability: while next_o_valid=1 and next_i_ready=0, next_o_data and next_o_valid hold.
- Ordering: strict FIFO order. No word is dropped or duplicated.
- Wrap-around: pointers wrap transparently. Full and empty detection stays correct across any number of wraps.
- Reset (synchronous; state takes reset values at the first rising edge with reset=1):
  - wr_ptr=0, rd_ptr=0, all storage entries cleared to 0.
  - o_count=0, o_empty=1, o_full=0.
  - next_o_data=0, next_o_valid=0, prev_o_ready=0 while reset=1.
  - prev_o_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation: all queued contents are discarded. Any push or pop handshake coinciding with reset=1 is void, and no words survive.
- No X propagation: every output is defined from the first post-reset cycle.

Test Plan:
- Reset then idle: hold reset 2 cycles, then release -> o_empty=1, o_count=0, next_o_valid=0, prev_o_ready=1, next_o_data=0.
- Fill and drain (depth 4): push 0x11,0x22,0x33,0x44 with next_i_ready=0.
  - After 4 edges: o_full=1, prev_o_ready=0, o_count=4, next_o_data=0x11.
  - A 5th push of 0x55 is refused.
  - Then set next_i_ready=1 -> outputs 0x11,0x22,0x33,0x44 on 4 consecutive cycles, then o_empty=1.
- Streaming with wrap: push 0x00000000..0x00000013 (20 words) with prev_i_valid=1 and next_i_ready=1 continuously -> 1-cycle latency, one word per cycle, in order, o_count stays 1, pointers wrap 5 times.
- Full with simultaneous pop: FIFO full, next_i_ready=1, prev_i_valid=1 with 0xAA -> pop only; o_count drops 4->3. 0xAA is accepted on the next edge and o_count returns to 4.
- Back-pressure hold: 2 entries (0xDEAD, 0xBEEF), next_i_ready=0 for 5 cycles -> next_o_data stays 0xDEAD and next_o_valid stays 1. Release -> 0xDEAD, then 0xBEEF.
- Reset mid-operation: 3 entries queued, assert reset 1 cycle during a push of 0x77 -> o_count=0, next_o_valid=0. 0x77 never appears at the output.

Source files
------------

// File: rtl/common_fifo_buffer.sv
// Synchronous first-word-fall-through FIFO with valid/ready on both sides.
// Wrap-bit pointers separate full from empty; storage clears on synchronous reset.
module common_fifo_buffer #(
  parameter int BUFFER_WIDTH      = 32,
  parameter int BUFFER_DEPTH_LOG2 = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BUFFER_WIDTH-1:0]      prev_i_data,
  input  logic                         prev_i_valid,
  output logic                         prev_o_ready,
  output logic [BUFFER_WIDTH-1:0]      next_o_data,
  output logic                         next_o_valid,
  input  logic                         next_i_ready,
  output logic [BUFFER_DEPTH_LOG2:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int DEPTH = 1 << BUFFER_DEPTH_LOG2;
  localparam int PW    = BUFFER_DEPTH_LOG2 + 1;

  logic [BUFFER_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;

  // Same slot with opposite wrap bits means the writer has lapped the reader.
  assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign prev_o_ready = !w_full && !reset;
  assign next_o_valid = !w_empty && !reset;
  assign next_o_data  = reset ? {BUFFER_WIDTH{1'b0}} : r_mem[r_rd_ptr[PW-2:0]];

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_full  = w_full;
  assign o_empty = w_empty;

  assign w_push = prev_i_valid && prev_o_ready;
  assign w_pop  = next_o_valid && next_i_ready;

  // Pointer advance on handshakes; reset voids any coinciding handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // Storage write; cleared on reset so no stale data is ever observable.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {BUFFER_WIDTH{1'b0}};
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr[PW-2:0]] <= prev_i_data;
    end else begin
      r_mem <= r_mem;
    end
  end

endmodule

// File: tb/tb_common_fifo_buffer.sv
// Scoreboard bench for common_fifo_buffer: a queue-based reference model fed by
// the stimulus side, and a negedge monitor comparing DUT outputs against it.
module tb_common_fifo_buffer;

  localparam int W     = 32;
  localparam int LOG2  = 2;
  localparam int DEPTH = 1 << LOG2;

  logic            clk = 1'b0;
  logic            reset;
  logic [W-1:0]    prev_i_data;
  logic            prev_i_valid;
  logic            prev_o_ready;
  logic [W-1:0]    next_o_data;
  logic            next_o_valid;
  logic            next_i_ready;
  logic [LOG2:0]   o_count;
  logic            o_full;
  logic            o_empty;

  int n_tests = 0;
  int n_fail  = 0;
  int n_popped = 0;

  logic [W-1:0] exp_q[$];

  common_fifo_buffer #(.BUFFER_WIDTH(W), .BUFFER_DEPTH_LOG2(LOG2)) dut (
    .clk          (clk),
    .reset        (reset),
    .prev_i_data  (prev_i_data),
    .prev_i_valid (prev_i_valid),
    .prev_o_ready (prev_o_ready),
    .next_o_data  (next_o_data),
    .next_o_valid (next_o_valid),
    .next_i_ready (next_i_ready),
    .o_count      (o_count),
    .o_full       (o_full),
    .o_empty      (o_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the FIFO is just an ordered list of accepted words.
  always @(posedge clk) begin
    int sz;
    if (reset) begin
      exp_q.delete();
    end else begin
      sz = exp_q.size();
      if (sz > 0 && next_i_ready) begin
        void'(exp_q.pop_front());
      end
      if (prev_i_valid && sz < DEPTH) begin
        exp_q.push_back(prev_i_data);
      end
    end
  end

  // Monitor: compare every visible output against the model each cycle.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_ready", {63'd0, prev_o_ready}, 64'd0);
      check("rst_valid", {63'd0, next_o_valid}, 64'd0);
      check("rst_data", {32'd0, next_o_data}, 64'd0);
    end else begin
      check("count", {61'd0, o_count}, 64'(exp_q.size()));
      check("full", {63'd0, o_full}, {63'd0, exp_q.size() == DEPTH});
      check("empty", {63'd0, o_empty}, {63'd0, exp_q.size() == 0});
      check("ready", {63'd0, prev_o_ready}, {63'd0, exp_q.size() < DEPTH});
      check("valid", {63'd0, next_o_valid}, {63'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) begin
        check("head_data", {32'd0, next_o_data}, {32'd0, exp_q[0]});
        if (next_o_valid && next_i_ready) n_popped++;
      end
    end
  end

  initial begin
    reset        = 1'b1;
    prev_i_data  = 32'd0;
    prev_i_valid = 1'b0;
    next_i_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("idle_empty", {63'd0, o_empty}, 64'd1);
    check("idle_ready", {63'd0, prev_o_ready}, 64'd1);
    check("idle_data", {32'd0, next_o_data}, 64'd0);

    // Fill with consumer stalled, then a refused fifth push.
    for (int i = 1; i <= 4; i++) begin
      prev_i_valid = 1'b1;
      prev_i_data  = 32'(i * 17);
      step();
    end
    prev_i_data = 32'h55;
    @(negedge clk);
    check("fill_full", {63'd0, o_full}, 64'd1);
    check("fill_count", {61'd0, o_count}, 64'd4);
    check("fill_head", {32'd0, next_o_data}, 64'h11);
    check("fill_ready", {63'd0, prev_o_ready}, 64'd0);
    step();
    prev_i_valid = 1'b0;
    next_i_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    check("drain_empty", {63'd0, o_empty}, 64'd1);

    // Streaming across several pointer wraps.
    for (int i = 0; i < 20; i++) begin
      prev_i_valid = 1'b1;
      prev_i_data  = 32'(i);
      step();
      @(negedge clk);
      check("stream_count", {61'd0, o_count}, 64'd1);
    end
    prev_i_valid = 1'b0;
    step();

    // Full with a simultaneous pop: no ready pass-through.
    next_i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prev_i_valid = 1'b1;
      prev_i_data  = $urandom;
      step();
    end
    prev_i_data  = 32'hAA;
    next_i_ready = 1'b1;
    step();
    @(negedge clk);
    check("fullpop_count", {61'd0, o_count}, 64'd3);
    next_i_ready = 1'b0;
    step();
    @(negedge clk);
    check("fullpop_refill", {61'd0, o_count}, 64'd4);
    prev_i_valid = 1'b0;
    next_i_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Back-pressure hold.
    next_i_ready = 1'b0;
    prev_i_valid = 1'b1;
    prev_i_data  = 32'hDEAD;
    step();
    prev_i_data  = 32'hBEEF;
    step();
    prev_i_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_data", {32'd0, next_o_data}, 64'hDEAD);
      check("hold_valid", {63'd0, next_o_valid}, 64'd1);
    end
    next_i_ready = 1'b1;
    step();
    step();

    // Reset mid-operation during a push of 0x77.
    next_i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      prev_i_valid = 1'b1;
      prev_i_data  = 32'h100 + 32'(i);
      step();
    end
    prev_i_data = 32'h77;
    reset       = 1'b1;
    step();
    reset        = 1'b0;
    prev_i_valid = 1'b0;
    @(negedge clk);
    check("midrst_count", {61'd0, o_count}, 64'd0);
    check("midrst_valid", {63'd0, next_o_valid}, 64'd0);
    next_i_ready = 1'b1;
    step();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      prev_i_valid = 1'($urandom_range(0, 1));
      next_i_ready = 1'($urandom_range(0, 2) != 0);
      prev_i_data  = $urandom;
      reset        = ($urandom_range(0, 59) == 0);
      step();
    end
    reset        = 1'b0;
    prev_i_valid = 1'b0;
    next_i_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    @(negedge clk);
    check("final_empty", {63'd0, o_empty}, 64'd1);
    check("pops_seen", 64'(n_popped > 40), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
